ctrl_seq: RTL and testbench

Microcoded control sequencer for the 8-bit bus CPU. It drives the program counter's `pc_inc` / `load_pc` / `pc_oen` and every other register-enable on the shared tri-state bus. Each instruction runs a fixed six-state T-cycle: three fetch states and three execute states. It is the controlling end of the PC, MAR, IR, memory and ALU interfaces.

---
 rtl/ctrl_pkg.sv | 26 ++
 rtl/tstate_cnt.sv | 46 ++++
 rtl/ctrl_seq.sv | 143 ++++++++++++++
 tb/tb_ctrl_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the control sequencer: opcode map and T-state encoding.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0     = 3'd0,
    T1     = 3'd1,
    T2     = 3'd2,
    T3     = 3'd3,
    T4     = 3'd4,
    T5     = 3'd5,
    T_HALT = 3'd6
  } tstate_e;

endpackage

// File: rtl/tstate_cnt.sv
// T-state register: six-state wrap T0..T5, HALT entry on HLT at T3, async clear on clr.
module tstate_cnt
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  output logic [2:0] state
);

  tstate_e state_r;
  tstate_e state_nxt_s;

  // state register, cleared asynchronously to T0
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= T0;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state: unconditional wrap, HALT is absorbing until clr
  always_comb begin
    state_nxt_s = T0;
    case (state_r)
      T0:     state_nxt_s = T1;
      T1:     state_nxt_s = T2;
      T2:     state_nxt_s = T3;
      T3: begin
        if (opcode == OP_HLT) begin
          state_nxt_s = T_HALT;
        end else begin
          state_nxt_s = T4;
        end
      end
      T4:     state_nxt_s = T5;
      T5:     state_nxt_s = T0;
      T_HALT: state_nxt_s = T_HALT;
      default: state_nxt_s = T0;
    endcase
  end

  assign state = state_r;

endmodule

// File: rtl/ctrl_seq.sv
// Microcoded control sequencer for the 8-bit bus CPU: decodes T-state, opcode and flags into bus enables.
// Optional macro CTRL_SEQ_COND_JMP_EN enables the JZ/JC conditional jumps.
module ctrl_seq
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  input  logic       flag_z,
  input  logic       flag_c,
  output logic       pc_inc,
  output logic       load_pc,
  output logic       pc_oen,
  output logic       mar_inen,
  output logic       mem_oen,
  output logic       mem_wen,
  output logic       ir_inen,
  output logic       ir_oen,
  output logic       acc_inen,
  output logic       acc_oen,
  output logic       b_inen,
  output logic       alu_oen,
  output logic       alu_sub,
  output logic       flags_inen,
  output logic       out_inen,
  output logic       halt,
  output logic [2:0] t_state
);

  logic [2:0] state_s;
  tstate_e    st_s;

  tstate_cnt u_tstate_cnt (
    .clk    (clk),
    .clr    (clr),
    .opcode (opcode),
    .state  (state_s)
  );

  assign st_s    = tstate_e'(state_s);
  assign t_state = state_s;

`ifndef CTRL_SEQ_COND_JMP_EN
  logic unused_flags_s;
  assign unused_flags_s = flag_z ^ flag_c;
`endif

  // control decode; clr gates everything so outputs drop without waiting for a clock
  always_comb begin
    pc_inc     = 1'b0;
    load_pc    = 1'b0;
    pc_oen     = 1'b0;
    mar_inen   = 1'b0;
    mem_oen    = 1'b0;
    mem_wen    = 1'b0;
    ir_inen    = 1'b0;
    ir_oen     = 1'b0;
    acc_inen   = 1'b0;
    acc_oen    = 1'b0;
    b_inen     = 1'b0;
    alu_oen    = 1'b0;
    alu_sub    = 1'b0;
    flags_inen = 1'b0;
    out_inen   = 1'b0;
    halt       = 1'b0;
    if (clr) begin
      halt = 1'b0;
    end else begin
      case (st_s)
        T0: begin
          pc_oen   = 1'b1;
          mar_inen = 1'b1;
        end
        T1: pc_inc = 1'b1;
        T2: begin
          mem_oen = 1'b1;
          ir_inen = 1'b1;
        end
        T3: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_oen   = 1'b1;
              mar_inen = 1'b1;
            end
            OP_LDI: begin
              ir_oen   = 1'b1;
              acc_inen = 1'b1;
            end
            OP_JMP: begin
              ir_oen  = 1'b1;
              load_pc = 1'b1;
            end
`ifdef CTRL_SEQ_COND_JMP_EN
            OP_JZ: begin
              ir_oen  = flag_z;
              load_pc = flag_z;
            end
            OP_JC: begin
              ir_oen  = flag_c;
              load_pc = flag_c;
            end
`endif
            OP_OUT: begin
              acc_oen  = 1'b1;
              out_inen = 1'b1;
            end
            default: ir_oen = 1'b0;
          endcase
        end
        T4: begin
          case (opcode)
            OP_LDA: begin
              mem_oen  = 1'b1;
              acc_inen = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              mem_oen = 1'b1;
              b_inen  = 1'b1;
            end
            OP_STA: begin
              acc_oen = 1'b1;
              mem_wen = 1'b1;
            end
            default: mem_oen = 1'b0;
          endcase
        end
        T5: begin
          if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
            alu_oen    = 1'b1;
            acc_inen   = 1'b1;
            flags_inen = 1'b1;
            alu_sub    = (opcode == OP_SUB);
          end else begin
            alu_oen = 1'b0;
          end
        end
        T_HALT: halt = 1'b1;
        default: halt = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: per-cycle behavioural model plus directed literal checks.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       flag_z = 1'b0;
  logic       flag_c = 1'b0;
  logic pc_inc, load_pc, pc_oen, mar_inen, mem_oen, mem_wen, ir_inen, ir_oen;
  logic acc_inen, acc_oen, b_inen, alu_oen, alu_sub, flags_inen, out_inen, halt;
  logic [2:0] t_state;

  int checks = 0;
  int failures = 0;

  ctrl_seq dut (
    .clk(clk), .clr(clr), .opcode(opcode), .flag_z(flag_z), .flag_c(flag_c),
    .pc_inc(pc_inc), .load_pc(load_pc), .pc_oen(pc_oen), .mar_inen(mar_inen),
    .mem_oen(mem_oen), .mem_wen(mem_wen), .ir_inen(ir_inen), .ir_oen(ir_oen),
    .acc_inen(acc_inen), .acc_oen(acc_oen), .b_inen(b_inen), .alu_oen(alu_oen),
    .alu_sub(alu_sub), .flags_inen(flags_inen), .out_inen(out_inen), .halt(halt),
    .t_state(t_state)
  );

  always #5 clk = ~clk;

  // bit positions in the packed control vector
  localparam int B_PC_INC = 15, B_LOAD_PC = 14, B_PC_OEN = 13, B_MAR = 12;
  localparam int B_MEM_OEN = 11, B_MEM_WEN = 10, B_IR_INEN = 9, B_IR_OEN = 8;
  localparam int B_ACC_INEN = 7, B_ACC_OEN = 6, B_B_INEN = 5, B_ALU_OEN = 4;
  localparam int B_ALU_SUB = 3, B_FLAGS = 2, B_OUT = 1, B_HALT = 0;

  logic [15:0] ctl;
  assign ctl = {pc_inc, load_pc, pc_oen, mar_inen, mem_oen, mem_wen, ir_inen, ir_oen,
                acc_inen, acc_oen, b_inen, alu_oen, alu_sub, flags_inen, out_inen, halt};

`ifdef CTRL_SEQ_COND_JMP_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  // microcode table: expected enables per opcode and phase of the instruction
  logic [15:0] utab [16][6];
  int  m_phase = 0;
  bit  m_halt = 1'b0;
  bit  cmp_en = 1'b1;

  function automatic logic [15:0] bv(input int b);
    logic [15:0] v;
    v = 16'h0000;
    v[b] = 1'b1;
    return v;
  endfunction

  initial begin
    for (int op = 0; op < 16; op++) begin
      for (int p = 0; p < 6; p++) utab[op][p] = 16'h0000;
      utab[op][0] = bv(B_PC_OEN) | bv(B_MAR);
      utab[op][1] = bv(B_PC_INC);
      utab[op][2] = bv(B_MEM_OEN) | bv(B_IR_INEN);
    end
    utab[1][3] = bv(B_IR_OEN) | bv(B_MAR);
    utab[1][4] = bv(B_MEM_OEN) | bv(B_ACC_INEN);
    for (int op = 2; op <= 3; op++) begin
      utab[op][3] = bv(B_IR_OEN) | bv(B_MAR);
      utab[op][4] = bv(B_MEM_OEN) | bv(B_B_INEN);
      utab[op][5] = bv(B_ALU_OEN) | bv(B_ACC_INEN) | bv(B_FLAGS);
    end
    utab[3][5] = utab[3][5] | bv(B_ALU_SUB);
    utab[4][3] = bv(B_IR_OEN) | bv(B_MAR);
    utab[4][4] = bv(B_ACC_OEN) | bv(B_MEM_WEN);
    utab[5][3] = bv(B_IR_OEN) | bv(B_ACC_INEN);
    utab[6][3] = bv(B_IR_OEN) | bv(B_LOAD_PC);
    utab[14][3] = bv(B_ACC_OEN) | bv(B_OUT);
  end

  function automatic logic [15:0] model_ctl(input bit c, input bit hl, input int ph,
                                            input logic [3:0] op, input logic fz, input logic fc);
    logic [15:0] v;
    if (c) return 16'h0000;
    if (hl) return bv(B_HALT);
    v = utab[op][ph];
    if (ph == 3 && COND_EN && ((op == 4'h7 && fz) || (op == 4'h8 && fc)))
      v = bv(B_IR_OEN) | bv(B_LOAD_PC);
    return v;
  endfunction

  // model position: cycles since clr, wrapping every six, absorbed by HLT at phase 3
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_phase <= 0;
      m_halt  <= 1'b0;
    end else if (!m_halt) begin
      if (m_phase == 3 && opcode == 4'hF) m_halt <= 1'b1;
      else m_phase <= (m_phase + 1) % 6;
    end
  end

  // per-cycle compare against the model plus bus invariants
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [15:0] e;
      logic [2:0]  et;
      e  = model_ctl(clr, m_halt, m_phase, opcode, flag_z, flag_c);
      et = clr ? 3'd0 : (m_halt ? 3'd6 : 3'(m_phase));
      checks++;
      if (ctl !== e || t_state !== et) begin
        failures++;
        $display("FAIL model t=%0t ctl=%h t_state=%0d required ctl=%h t_state=%0d op=%h",
                 $time, ctl, t_state, e, et, opcode);
      end
      checks++;
      if ((32'(pc_oen) + 32'(mem_oen) + 32'(ir_oen) + 32'(acc_oen) + 32'(alu_oen)) > 1 ||
          (pc_inc && load_pc) || (mem_wen && mem_oen)) begin
        failures++;
        $display("FAIL invariant t=%0t ctl=%h required no bus conflict", $time, ctl);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  logic [15:0] cap [6];
  logic [2:0]  cap_t [6];

  // runs one instruction from T0, capturing mid-cycle outputs of each phase
  task automatic run_instr(input logic [3:0] op, input logic fz, input logic fc);
    opcode = op; flag_z = fz; flag_c = fc;
    for (int p = 0; p < 6; p++) begin
      #3;
      cap[p] = ctl; cap_t[p] = t_state;
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", ctl, 16'h0000);
    chk("reset_tstate", 16'(t_state), 16'h0000);
    clr = 1'b0;

    run_instr(4'h0, 1'b0, 1'b0);
    chk("fetch_t0", cap[0], 16'h3000);
    chk("fetch_t1", cap[1], 16'h8000);
    chk("fetch_t2", cap[2], 16'h0A00);
    chk("nop_t3_t5", cap[3] | cap[4] | cap[5], 16'h0000);
    chk("wrap_tstate", 16'(t_state), 16'h0000);

    run_instr(4'h2, 1'b0, 1'b0);
    chk("add_t3", cap[3], 16'h1100);
    chk("add_t4", cap[4], 16'h0820);
    chk("add_t5", cap[5], 16'h0094);
    run_instr(4'h3, 1'b0, 1'b0);
    chk("sub_t5", cap[5], 16'h009C);

    run_instr(4'h7, 1'b1, 1'b0);
    chk("jz_taken_t3", cap[3], COND_EN ? 16'h4100 : 16'h0000);
    run_instr(4'h7, 1'b0, 1'b1);
    chk("jz_not_taken_t3", cap[3], 16'h0000);
    run_instr(4'h8, 1'b0, 1'b1);
    chk("jc_taken_t3", cap[3], COND_EN ? 16'h4100 : 16'h0000);
    run_instr(4'h6, 1'b0, 1'b0);
    chk("jmp_t3", cap[3], 16'h4100);

    // STA aborted by clr during T4
    opcode = 4'h4;
    repeat (4) @(posedge clk);
    #3;
    chk("sta_t4_wen", 16'(mem_wen), 16'h0001);
    clr = 1'b1;
    #1;
    chk("sta_clr_wen", 16'(mem_wen), 16'h0000);
    chk("sta_clr_tstate", 16'(t_state), 16'h0000);
    @(posedge clk); #1 clr = 1'b0;
    run_instr(4'h4, 1'b0, 1'b0);
    chk("sta_retry_t4", cap[4], 16'h0440);

    // HLT then 100 cycles of ignored inputs
    opcode = 4'hF;
    repeat (4) @(posedge clk);
    #3;
    chk("hlt_halt", ctl, 16'h0001);
    chk("hlt_tstate", 16'(t_state), 16'h0006);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      opcode = 4'($urandom_range(15, 0));
      flag_z = 1'($urandom_range(1, 0));
      flag_c = 1'($urandom_range(1, 0));
    end
    pulse_clr();
    #1;
    chk("post_halt_tstate", 16'(t_state), 16'h0000);
    chk("post_halt_pc_oen", 16'(pc_oen), 16'h0001);
    #2;

    // random opcode stream, HLT excluded so the stream keeps running
    for (int i = 0; i < 1000; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(14, 0));
      run_instr(op, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
